// File: rtl/retire_reclaim_if.sv
// Rename/execute-facing bundle of the retirement queue: alloc handshake, completion, flush
// and the registered retire/free outputs. master = rename/exec side, slave = the queue.
interface retire_reclaim_if #(
  parameter int PHYS_REGS = 16,
  parameter int DEPTH     = 8
);
  localparam int PW = $clog2(PHYS_REGS);
  localparam int TW = $clog2(DEPTH);

  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [2*PW-1:0]      alloc_new;
  logic [2*PW-1:0]      alloc_old;
  logic [TW-1:0]        alloc_tag;
  logic                 complete_valid;
  logic [TW-1:0]        complete_tag;
  logic                 flush;
  logic                 retire_valid;
  logic [TW-1:0]        retire_tag;
  logic [PHYS_REGS-2:0] free_mask;
  logic [TW:0]          count;

  modport master (
    output alloc_valid, alloc_new, alloc_old, complete_valid, complete_tag, flush,
    input  alloc_ready, alloc_tag, retire_valid, retire_tag, free_mask, count
  );

  modport slave (
    input  alloc_valid, alloc_new, alloc_old, complete_valid, complete_tag, flush,
    output alloc_ready, alloc_tag, retire_valid, retire_tag, free_mask, count
  );
endinterface

// File: rtl/retire_reclaim.sv
// In-order retire queue returning stale phys regs (or, on flush, un-retired allocations) as a
// 1-cycle free_mask pulse; retire 1 cycle after done is seen; alloc_ready drops when full or flushing.
module retire_reclaim #(
  parameter int PHYS_REGS = 16,
  parameter int DEPTH     = 8
) (
  input logic              clk,
  input logic              rst,
  retire_reclaim_if.slave  bus
);
  localparam int PW = $clog2(PHYS_REGS);
  localparam int TW = $clog2(DEPTH);

  typedef struct packed {
    logic          valid;
    logic          done;
    logic [PW-1:0] new1;
    logic [PW-1:0] new0;
    logic [PW-1:0] old1;
    logic [PW-1:0] old0;
  } entry_t;

  entry_t               ent_q [DEPTH];
  entry_t               ent_d [DEPTH];
  logic [TW-1:0]        head_q, head_d;
  logic [TW-1:0]        tail_q, tail_d;
  logic [TW:0]          count_q, count_d;
  logic                 retire_valid_q, retire_valid_d;
  logic [TW-1:0]        retire_tag_q, retire_tag_d;
  logic [PHYS_REGS-2:0] free_mask_q, free_mask_d;
  logic                 do_alloc;
  logic                 do_retire;

  // Reg 0 is the discard reg and out-of-range indices match no bit, so both drop out here.
  function automatic logic [PHYS_REGS-2:0] reg_oh(input logic [PW-1:0] r);
    reg_oh = '0;
    for (int i = 1; i < PHYS_REGS; i++) begin
      if (int'(r) == i) reg_oh[i-1] = 1'b1;
    end
  endfunction

  assign bus.alloc_ready  = (count_q < (TW+1)'(DEPTH)) & ~bus.flush;
  assign bus.alloc_tag    = tail_q;
  assign bus.retire_valid = retire_valid_q;
  assign bus.retire_tag   = retire_tag_q;
  assign bus.free_mask    = free_mask_q;
  assign bus.count        = count_q;

  assign do_alloc  = bus.alloc_valid & bus.alloc_ready;
  assign do_retire = (count_q != '0) & ent_q[head_q].valid & ent_q[head_q].done & ~bus.flush;

  always_comb begin
    ent_d          = ent_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    retire_valid_d = 1'b0;
    retire_tag_d   = retire_tag_q;
    free_mask_d    = '0;

    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid) begin
          free_mask_d = free_mask_d | reg_oh(ent_q[i].new0) | reg_oh(ent_q[i].new1);
        end
        ent_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (bus.complete_valid && ent_q[bus.complete_tag].valid) begin
        ent_d[bus.complete_tag].done = 1'b1;
      end
      if (do_retire) begin
        ent_d[head_q].valid = 1'b0;
        ent_d[head_q].done  = 1'b0;
        head_d              = head_q + 1'b1;
        retire_valid_d      = 1'b1;
        retire_tag_d        = head_q;
        free_mask_d         = reg_oh(ent_q[head_q].old0) | reg_oh(ent_q[head_q].old1);
      end
      // Written last so a same-cycle completion to the tail slot cannot pre-mark the new op done.
      if (do_alloc) begin
        ent_d[tail_q] = '{valid: 1'b1, done: 1'b0,
                          new1: bus.alloc_new[2*PW-1:PW], new0: bus.alloc_new[PW-1:0],
                          old1: bus.alloc_old[2*PW-1:PW], old0: bus.alloc_old[PW-1:0]};
        tail_d        = tail_q + 1'b1;
      end
      count_d = count_q + (TW+1)'(do_alloc) - (TW+1)'(do_retire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      retire_valid_q <= 1'b0;
      retire_tag_q   <= '0;
      free_mask_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      retire_valid_q <= retire_valid_d;
      retire_tag_q   <= retire_tag_d;
      free_mask_q    <= free_mask_d;
    end
  end
endmodule
